// File: rtl/pending_encoder_pkg.sv
// Shared types and helpers for the pending-request priority encoder.
package pending_encoder_pkg;

    typedef enum logic {
        S_IDLE    = 1'b0,
        S_PRESENT = 1'b1
    } state_t;

    localparam int N_DEFAULT = 4;
    localparam int N_MAX     = 16;

    // Callers truncate the result to their own request width.
    function automatic logic [N_MAX-1:0] onehot(input int unsigned idx);
        return {{(N_MAX-1){1'b0}}, 1'b1} << idx;
    endfunction

endpackage

// File: rtl/prio_enc_comb.sv
// Combinational lowest-set-bit encoder: index 0 has the highest priority.
module prio_enc_comb #(
    parameter int N = 4,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] vec,
    output logic [W-1:0] idx,
    output logic         any
);

    always_comb begin
        idx = '0;
        any = |vec;
        // Walk from the top down so the lowest set bit is the last one written.
        for (int i = N - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = W'(i);
            end
        end
    end

endmodule

// File: rtl/pending_encoder.sv
// Latches request pulses into a pending set and hands out the lowest pending
// index one at a time over a valid/ready handshake.
module pending_encoder
    import pending_encoder_pkg::*;
#(
    parameter int N = N_DEFAULT,
    localparam int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [N-1:0] req,
    input  logic         ready,
    output logic [W-1:0] code,
    output logic         valid,
    output logic [N-1:0] pending,
    output logic         multi,
    output state_t       state
);

    // Handshake: a code transfers on any rising edge where valid && ready.
    // Once valid rises, code stays fixed until that transfer; ready is
    // ignored while valid is low.

    logic [W-1:0] enc_idx;
    logic         enc_any;
    logic [N-1:0] clr;

    prio_enc_comb #(.N(N)) u_prio (
        .vec (pending),
        .idx (enc_idx),
        .any (enc_any)
    );

    assign clr   = (valid && ready) ? N'(onehot(32'(code))) : '0;
    assign multi = |(pending & (pending - N'(1)));

    // A request landing on the bit being cleared wins, so it is served again.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
            code    <= '0;
            valid   <= 1'b0;
            state   <= S_IDLE;
        end else begin
            pending <= (pending & ~clr) | (en ? req : '0);
            case (state)
                S_IDLE: begin
                    if (enc_any) begin
                        code  <= enc_idx;
                        valid <= 1'b1;
                        state <= S_PRESENT;
                    end
                end
                S_PRESENT: begin
                    if (ready) begin
                        valid <= 1'b0;
                        state <= S_IDLE;
                    end
                end
                default: begin
                    valid <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/pending_encoder.md
Name: pending_encoder

Overview:
- Sequential N-to-log2(N) priority encoder, the encode-direction counterpart of the 2-to-4 decoder.
- Latches request lines into a pending register and presents the highest-priority pending index as a binary code. Index 0 has the highest priority.
- Hands each code out on a valid/ready handshake and clears the served request on acceptance.
- Sits in front of the decoder: the encoded index plus valid can drive the decoder's select and enable inputs.

Parameters:
- N, 4, number of request lines; power of two, 2..16.
- W, $clog2(N) = 2, width of the encoded index; derived, not overridden.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset; asserted asynchronously, released synchronously to clk.
- en  input  1  capture enable; req is sampled only when en=1.
- req  input  N  request lines, sampled each edge; a one-cycle pulse is sufficient.
- ready  input  1  consumer accepts the presented code.
- code  output  W  encoded index of the presented request.
- valid  output  1  code is meaningful.
- pending  output  N  current pending register, for visibility.
- multi  output  1  more than one bit of pending is set.

Behaviour:
- Reset (rst_n=0, immediate): pending=0, code=0, valid=0, multi=0, state=S_IDLE. Reset mid-handshake discards everything; no code is replayed afterwards.
- Pending update at each edge: pending <= (pending & ~clr) | (en ? req : 0).
  - clr is the one-hot of code when valid && ready; otherwise clr=0.
  - Same-edge conflict: if a req bit equals the bit being cleared, the set wins and the bit stays pending; it is served again later.
  - A req on an already-pending bit is absorbed, not counted.
- FSM has two states.
  - S_IDLE: valid=0. If pending!=0 at an edge: code <= index of the lowest set bit of pending, valid <= 1, go to S_PRESENT.
  - S_PRESENT: valid=1, and code is held stable while ready=0. No preemption: a higher-priority request arriving now waits.
  - S_PRESENT, ready=1 at an edge: the presented bit is cleared, valid <= 0, return to S_IDLE.
- Throughput: one bubble cycle between consecutive codes, so at most 1 code per 2 cycles.
- Latency: req sampled at edge E0 gives valid=1 with the correct code after E1 (2 edges).
- Encoder source is the registered pending value (pre-update), so a req captured at the same edge is not visible until the next one.
- multi = popcount(pending) > 1; combinational from the pending register.
- en=0: no capture. Pending drain and the handshake continue normally.
- ready while valid=0 is ignored.
- pending=all ones drains in order 0,1,...,N-1 with ready tied high: 2N cycles.

Decomposition:
- Shared package pending_encoder_pkg:
  - state enum S_IDLE/S_PRESENT;
  - default N;
  - function onehot(idx) returning the N-bit one-hot mask.
- One sub-module, prio_enc_comb (parameter N): purely combinational, N-bit vector in, lowest-set-bit index (W bits) plus any-set flag out. It is reusable elsewhere and is tested alongside this block.

Test Plan:
- Reset: assert rst_n=0 mid-cycle while valid=1 and pending=4'b1010 -> outputs 0 immediately; after release, valid stays 0 until a new req arrives.
- Single request: en=1, req=4'b0100 pulse at E0 -> valid=1, code=2 after E1; ready=1 at E2 -> valid=0 and pending=0 after E2.
- Priority and no-preemption: pending=4'b1000 being presented (code=3, ready=0), then req=4'b0001 arrives -> code holds 3. After ready, the next code is 0, then 3 does not repeat; pending=0 at the end.
- Simultaneous set/clear: presenting code=1, ready=1 and req=4'b0010 at the same edge -> pending[1] stays 1; code=1 is presented again 2 edges later.
- Drain all: req=4'b1111 once, ready tied 1 -> code sequence 0,1,2,3 on alternate cycles. multi=1 until pending=4'b1000, then multi=0.
- Enable gating: en=0 with req=4'b0001 for 5 cycles -> pending=0, valid never rises. With en=1 and the same req -> code=0.
